// File: rtl/lc3b_dcache_responder_if.sv
// Pipeline data-memory and physical-memory signals shared by the LC-3b data cache.
// The slave modport is the cache's view; master is the pipeline/memory environment.
interface lc3b_dcache_responder_if;
  logic         mem_enable;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         mem_hit;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_enable, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, mem_hit,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_enable, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, mem_hit,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/lc3b_dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache for the LC-3b MEM stage.
// Optional hit/miss counters are enabled with `define DCACHE_PERF_CNT_EN.
module lc3b_dcache_responder #(
  parameter int unsigned IDX_BITS = 3
) (
  input  logic clk,
  input  logic rst,
  lc3b_dcache_responder_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0] perf_hits,
  output logic [15:0] perf_misses
`endif
);

  localparam int unsigned TAG_BITS = 12 - IDX_BITS;
  localparam int unsigned NUM_SETS = 2 ** IDX_BITS;

  typedef enum logic [1:0] {
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t               state_q;
  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
  logic [127:0]         data_q [NUM_SETS];
  logic                 pmem_read_q;
  logic                 pmem_write_q;
  logic [15:0]          pmem_addr_q;
  logic [127:0]         pmem_wdata_q;

  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  req_tag;
  logic [6:0]           bitpos;
  logic                 req;
  logic                 is_write;
  logic                 hit;
  logic                 resp;
  logic [127:0]         line;
  logic [127:0]         merged;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = bus.mem_address[0];

  always_comb begin
    idx      = bus.mem_address[4 +: IDX_BITS];
    req_tag  = bus.mem_address[15 -: TAG_BITS];
    bitpos   = {bus.mem_address[3:1], 4'b0000};
    req      = bus.mem_enable & (bus.mem_read | bus.mem_write);
    is_write = bus.mem_write;
    line     = data_q[idx];
    hit      = req & valid_q[idx] & (tag_q[idx] == req_tag);
    resp     = (state_q == S_COMPARE) & hit;
    merged   = line;
    if (bus.mem_byte_enable[0]) merged[bitpos +: 8]         = bus.mem_wdata[7:0];
    if (bus.mem_byte_enable[1]) merged[bitpos + 7'd8 +: 8]  = bus.mem_wdata[15:8];
  end

  assign bus.mem_hit      = hit;
  assign bus.mem_resp     = resp;
  assign bus.mem_rdata    = resp ? line[bitpos +: 16] : '0;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_addr_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

  // pmem_* are loaded on the state transition so they are clean flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COMPARE;
      valid_q      <= '0;
      dirty_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_COMPARE: begin
          if (resp) begin
            if (is_write && (bus.mem_byte_enable != 2'b00)) dirty_q[idx] <= 1'b1;
          end else if (req) begin
            if (dirty_q[idx]) begin
              state_q      <= S_WRITEBACK;
              pmem_write_q <= 1'b1;
              pmem_addr_q  <= {tag_q[idx], idx, 4'b0000};
              pmem_wdata_q <= line;
            end else begin
              state_q     <= S_ALLOCATE;
              pmem_read_q <= 1'b1;
              pmem_addr_q <= {req_tag, idx, 4'b0000};
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.pmem_resp) begin
            state_q      <= S_ALLOCATE;
            dirty_q[idx] <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_wdata_q <= '0;
            pmem_read_q  <= 1'b1;
            pmem_addr_q  <= {req_tag, idx, 4'b0000};
          end
        end
        S_ALLOCATE: begin
          if (bus.pmem_resp) begin
            state_q      <= S_COMPARE;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_addr_q  <= '0;
          end
        end
        default: state_q <= S_COMPARE;
      endcase
    end
  end

  // Tag and data contents need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (resp && is_write) begin
        data_q[idx] <= merged;
      end else if ((state_q == S_ALLOCATE) && bus.pmem_resp) begin
        data_q[idx] <= bus.pmem_rdata;
        tag_q[idx]  <= req_tag;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] hits_q;
  logic [15:0] misses_q;
  logic        missed_q;

  // missed_q remembers that the pending request already took a miss path.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      missed_q <= 1'b0;
    end else if (resp) begin
      missed_q <= 1'b0;
      if (!missed_q && (hits_q != '1)) hits_q <= hits_q + 16'd1;
    end else if ((state_q == S_COMPARE) && req) begin
      missed_q <= 1'b1;
      if (misses_q != '1) misses_q <= misses_q + 16'd1;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_lc3b_dcache_responder.sv
// Directed, table-driven bench for lc3b_dcache_responder (one table row per clock cycle),
// followed by hand-written reset-during-refill sequence.
module tb_lc3b_dcache_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3b_dcache_responder_if bus();

`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] perf_hits;
  logic [15:0] perf_misses;
  lc3b_dcache_responder #(.IDX_BITS(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .perf_hits(perf_hits), .perf_misses(perf_misses)
  );
`else
  lc3b_dcache_responder #(.IDX_BITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  localparam logic [127:0] LA = 128'h7777_6666_5555_4444_3333_BEEF_1111_0000;
  localparam logic [127:0] LC = 128'h7777_6666_5555_4444_3333_BEAA_1111_0000;
  localparam logic [127:0] LB = 128'hB7B7_B6B6_B5B5_B4B4_B3B3_B2B2_B1B1_B0B0;
  localparam logic [127:0] LD = 128'hD7D7_D6D6_D5D5_D4D4_D3D3_D2D2_D1D1_D0D0;

  typedef struct {
    logic         en, rd, wr;
    logic [15:0]  addr;
    logic [1:0]   be;
    logic [15:0]  wdata;
    logic         presp;
    logic [127:0] prdata;
    logic         e_resp, e_hit, e_rdchk;
    logic [15:0]  e_rdata;
    logic         e_pr, e_pw;
    logic [15:0]  e_paddr;
    logic [127:0] e_pwdata;
  } vec_t;

  vec_t vecs[$];
  int   tests    = 0;
  int   failures = 0;
  logic found;

  task automatic add(input logic en, input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [1:0] be, input logic [15:0] wdata, input logic presp,
                     input logic [127:0] prdata, input logic e_resp, input logic e_hit,
                     input logic e_rdchk, input logic [15:0] e_rdata, input logic e_pr,
                     input logic e_pw, input logic [15:0] e_paddr, input logic [127:0] e_pwdata);
    vec_t v;
    v.en = en; v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
    v.presp = presp; v.prdata = prdata;
    v.e_resp = e_resp; v.e_hit = e_hit; v.e_rdchk = e_rdchk; v.e_rdata = e_rdata;
    v.e_pr = e_pr; v.e_pw = e_pw; v.e_paddr = e_paddr; v.e_pwdata = e_pwdata;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [1:0] be, input logic [15:0] wdata, input logic presp,
                       input logic [127:0] prdata);
    bus.mem_enable      = en;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wdata;
    bus.pmem_resp       = presp;
    bus.pmem_rdata      = prdata;
  endtask

  task automatic chk(input int row, input string what, input logic [127:0] got,
                     input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL row%0d %s: got %h expected %h", row, what, got, exp);
    end
  endtask

  initial begin
    // en rd wr addr be wdata | presp prdata | resp hit rdchk rdata | pr pw paddr pwdata
    add(0, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, '0); // en=0 idle
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, '0); // cold miss
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0,  0, 0, 0, 16'h0000, 1, 0, 16'h0120, '0);
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 1, LA,  0, 0, 0, 16'h0000, 1, 0, 16'h0120, '0);
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'hBEEF, 0, 0, 16'h0000, '0);
    add(1, 1, 1, 16'h0124, 2'b01, 16'h12AA, 0, '0,  1, 1, 0, 16'h0000, 0, 0, 16'h0000, '0); // rd+wr = write
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'hBEAA, 0, 0, 16'h0000, '0);
    add(1, 1, 0, 16'h0122, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'h1111, 0, 0, 16'h0000, '0); // back-to-back
    add(1, 1, 0, 16'h012C, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'h6666, 0, 0, 16'h0000, '0);
    add(1, 0, 1, 16'h0120, 2'b00, 16'hFFFF, 0, '0,  1, 1, 0, 16'h0000, 0, 0, 16'h0000, '0); // be=00
    add(1, 1, 0, 16'h0120, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'h0000, 0, 0, 16'h0000, '0);
    add(1, 1, 0, 16'h0224, 2'b00, 16'h0000, 0, '0,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, '0); // dirty evict
    add(1, 1, 0, 16'h0224, 2'b00, 16'h0000, 0, '0,  0, 0, 0, 16'h0000, 0, 1, 16'h0120, LC);
    add(1, 1, 0, 16'h0224, 2'b00, 16'h0000, 1, '0,  0, 0, 0, 16'h0000, 0, 1, 16'h0120, LC);
    add(1, 1, 0, 16'h0224, 2'b00, 16'h0000, 0, '0,  0, 0, 0, 16'h0000, 1, 0, 16'h0220, '0);
    add(1, 1, 0, 16'h0224, 2'b00, 16'h0000, 1, LB,  0, 0, 0, 16'h0000, 1, 0, 16'h0220, '0);
    add(1, 1, 0, 16'h0224, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'hB2B2, 0, 0, 16'h0000, '0);
    add(0, 0, 0, 16'h0000, 2'b00, 16'h0000, 1, LD,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, '0); // stray pmem_resp
    add(1, 1, 0, 16'h0224, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'hB2B2, 0, 0, 16'h0000, '0);
    add(1, 0, 1, 16'h0226, 2'b00, 16'h5A5A, 0, '0,  1, 1, 0, 16'h0000, 0, 0, 16'h0000, '0); // be=00 on clean
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, '0);
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 1, LC,  0, 0, 0, 16'h0000, 1, 0, 16'h0120, '0); // no writeback
    add(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0,  1, 1, 1, 16'hBEAA, 0, 0, 16'h0000, '0);

    rst = 1'b1;
    drive(0, 0, 0, 16'h0000, 2'b00, 16'h0000, 0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk(-1, "reset mem_resp",     bus.mem_resp,     '0);
    chk(-1, "reset mem_hit",      bus.mem_hit,      '0);
    chk(-1, "reset mem_rdata",    bus.mem_rdata,    '0);
    chk(-1, "reset pmem_read",    bus.pmem_read,    '0);
    chk(-1, "reset pmem_write",   bus.pmem_write,   '0);
    chk(-1, "reset pmem_address", bus.pmem_address, '0);
    chk(-1, "reset pmem_wdata",   bus.pmem_wdata,   '0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata,
            vecs[i].presp, vecs[i].prdata);
      #2;
      chk(i, "mem_resp",   bus.mem_resp,   vecs[i].e_resp);
      chk(i, "mem_hit",    bus.mem_hit,    vecs[i].e_hit);
      chk(i, "pmem_read",  bus.pmem_read,  vecs[i].e_pr);
      chk(i, "pmem_write", bus.pmem_write, vecs[i].e_pw);
      if (vecs[i].e_rdchk) chk(i, "mem_rdata", bus.mem_rdata, vecs[i].e_rdata);
      if (vecs[i].e_pr || vecs[i].e_pw) chk(i, "pmem_address", bus.pmem_address, vecs[i].e_paddr);
      if (vecs[i].e_pw) chk(i, "pmem_wdata", bus.pmem_wdata, vecs[i].e_pwdata);
    end

    // Reset while a refill is outstanding, request held throughout.
    @(negedge clk);
    drive(1, 1, 0, 16'h0344, 2'b00, 16'h0000, 0, '0);
    #2;
    chk(-2, "rst_seq first mem_resp", bus.mem_resp, '0);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      #2;
      if (bus.pmem_read === 1'b1) found = 1'b1;
    end
    chk(-2, "rst_seq pmem_read seen", found, 128'd1);
    chk(-2, "rst_seq pmem_address", bus.pmem_address, 128'h0340);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk(-2, "rst_seq pmem_read dropped", bus.pmem_read,  '0);
    chk(-2, "rst_seq pmem_write low",    bus.pmem_write, '0);
    chk(-2, "rst_seq no mem_resp",       bus.mem_resp,   '0);
    chk(-2, "rst_seq no mem_hit",        bus.mem_hit,    '0);
    @(negedge clk);
    #2;
    chk(-2, "rst_seq re-miss pmem_read", bus.pmem_read,    128'd1);
    chk(-2, "rst_seq re-miss address",   bus.pmem_address, 128'h0340);
    chk(-2, "rst_seq re-miss mem_resp",  bus.mem_resp,     '0);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LD;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #2;
    chk(-2, "rst_seq refill mem_resp",  bus.mem_resp,  128'd1);
    chk(-2, "rst_seq refill mem_rdata", bus.mem_rdata, 128'hD2D2);
    @(negedge clk);
    drive(1, 1, 0, 16'h0124, 2'b00, 16'h0000, 0, '0);
    #2;
    chk(-2, "rst_seq old line invalid hit",  bus.mem_hit,  '0);
    chk(-2, "rst_seq old line invalid resp", bus.mem_resp, '0);
    @(negedge clk);
    drive(0, 0, 0, 16'h0000, 2'b00, 16'h0000, 0, '0);
    #2;
    chk(-2, "rst_seq old line refetch", bus.pmem_read, 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
